alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters (req0, req1) using round-robin arbitration.
//  Captures the winner's op/operands into registers and drives the ALU from them.
//  Samples the ALU result after EXEC_CYCLES cycles, then returns it on one response channel
//  tagged with the requester id. Sits between the issue logic and the single ALU instance.
// PARAMETERS
//  EXEC_CYCLES  1  cycles alu_* are held before alu_result is sampled (1..15)
// PORTS
//  clk          in   1   clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  req0_valid   in   1   requester 0 has an op pending
//  req0_ready   out  1   requester 0 op accepted this cycle (when valid & ready)
//  req0_op      in   4   ALU op code (0 add,1 sub,2 or,3 eq,4 lui,5 passA,6 sll)
//  req0_a       in   32  operand A
//  req0_b       in   32  operand B
//  req0_c       in   5   shift amount
//  req1_*       -    -   same set as req0_* for requester 1
//  alu_op       out  4   registered op to the ALU
//  alu_a        out  32  registered operand A to the ALU
//  alu_b        out  32  registered operand B to the ALU
//  alu_c        out  5   registered shift amount to the ALU
//  alu_result   in   32  ALU result (combinational from alu_*)
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   consumer accepts the response
//  rsp_id       out  1   requester that issued the op
//  rsp_result   out  32  sampled ALU result
// BEHAVIOUR
//  Reset state (asynchronous, immediate on reset_n low):
//   - state=IDLE, all outputs 0
//   - last_grant=1, so req0 wins the first tie
//  States:
//   - IDLE: grant = req0 if only req0 valid; req1 if only req1 valid.
//     If both are valid, grant the one != last_grant.
//   - reqX_ready = (state==IDLE) & grant==X. This is combinational from valids/state; no ready without valid.
//   - On handshake: latch op/a/b/c into alu_*, rsp_id<=X, last_grant<=X, cnt<=EXEC_CYCLES-1, go EXEC.
//   - EXEC: alu_* held stable. If cnt==0: rsp_result<=alu_result, rsp_valid<=1, go HOLD. Else cnt<=cnt-1.
//   - HOLD: rsp_valid, rsp_id, rsp_result held stable until rsp_ready=1.
//     On that edge: rsp_valid<=0, go IDLE.
//   - No new grant is made in the same cycle as the response handshake.
//  Latency and throughput:
//   - Handshake at edge N -> rsp_valid high after edge N+EXEC_CYCLES.
//   - One op per EXEC_CYCLES+2 cycles at best.
//  Other rules:
//   - alu_* keep their last values in IDLE/HOLD; they change only on a handshake.
//   - Op codes 7..15 are passed through unchanged; the result is whatever the ALU returns (0).
//   - reqX_valid deasserting while not granted is legal; nothing is latched.
//   - reset_n low in EXEC/HOLD aborts the transaction: the response is lost, and rsp_valid drops
//     with no clock edge needed.
//   - All arithmetic is the ALU's; this block does no data manipulation; 32-bit widths throughout.
// TESTING
//  1) EXEC_CYCLES=1, req0 op=0 a=5 b=7 -> req0_ready same cycle, rsp_valid 1 cycle later,
//     rsp_result=12, rsp_id=0
//  2) Both valid at first cycle after reset: req0 op=1 a=9 b=4, req1 op=2 a=0xF0 b=0x0F ->
//     responses in order id0 result 5, then id1 result 0xFF
//  3) rsp_ready low 5 cycles in HOLD -> rsp_valid/rsp_id/rsp_result constant, both readys 0, alu_* constant
//  4) req0 and req1 both held valid for 6 ops -> grant/rsp_id sequence 0,1,0,1,0,1
//  5) EXEC_CYCLES=3, req1 op=6 b=1 c=31 -> rsp after 3 cycles, result 0x80000000;
//     repeat with reset_n low in EXEC -> outputs 0 immediately, no rsp
//  6) req0 op=3 a=b=0xDEAD -> result 1; then op=4 b=0x1234 -> result 0x12340000

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters
// and returns each sampled result on a single id-tagged response channel.
module alu_share_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_c,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_c,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_c,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state_r;
  logic       last_grant_r;
  logic [3:0] cnt_r;
  logic       grant_s;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant_s = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant_s = 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ready is offered only in IDLE, only to the granted requester, and only while it is valid.
  always_comb begin
    req0_ready = (state_r == IDLE) && req0_valid && (grant_s == 1'b0);
    req1_ready = (state_r == IDLE) && req1_valid && (grant_s == 1'b1);
  end

  // Transaction FSM: capture winner, hold ALU inputs for EXEC_CYCLES, then hold the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= 4'd0;
      alu_op       <= 4'd0;
      alu_a        <= 32'd0;
      alu_b        <= 32'd0;
      alu_c        <= 5'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            alu_op       <= grant_s ? req1_op : req0_op;
            alu_a        <= grant_s ? req1_a  : req0_a;
            alu_b        <= grant_s ? req1_b  : req0_b;
            alu_c        <= grant_s ? req1_c  : req0_c;
            rsp_id       <= grant_s;
            last_grant_r <= grant_s;
            cnt_r        <= CNT_INIT;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_r == 4'd0) begin
            rsp_result <= alu_result;
            rsp_valid  <= 1'b1;
            state_r    <= HOLD;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        HOLD: begin
          // Returning to IDLE on the response handshake keeps a new grant out of that same edge.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: two arbiter instances (EXEC_CYCLES=1 and 3) each driving a reference ALU.
module tb_alu_share_arbiter;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  c;
    logic        id;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rstn  [2];
  logic        r0v   [2];
  logic        r0rdy [2];
  logic [3:0]  r0op  [2];
  logic [31:0] r0a   [2];
  logic [31:0] r0b   [2];
  logic [4:0]  r0c   [2];
  logic        r1v   [2];
  logic        r1rdy [2];
  logic [3:0]  r1op  [2];
  logic [31:0] r1a   [2];
  logic [31:0] r1b   [2];
  logic [4:0]  r1c   [2];
  logic [3:0]  aop   [2];
  logic [31:0] aa    [2];
  logic [31:0] ab    [2];
  logic [4:0]  ac    [2];
  logic [31:0] ares  [2];
  logic        rv    [2];
  logic        rrdy  [2];
  logic        rid   [2];
  logic [31:0] rres  [2];

  int checks = 0;
  int fails  = 0;
  vec_t vecs [8];

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] c);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a | b;
      4'd3:    return {31'd0, a == b};
      4'd4:    return {b[15:0], 16'd0};
      4'd5:    return a;
      4'd6:    return b << c;
      default: return 32'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_share_arbiter #(.EXEC_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset_n(rstn[g]),
      .req0_valid(r0v[g]), .req0_ready(r0rdy[g]), .req0_op(r0op[g]),
      .req0_a(r0a[g]), .req0_b(r0b[g]), .req0_c(r0c[g]),
      .req1_valid(r1v[g]), .req1_ready(r1rdy[g]), .req1_op(r1op[g]),
      .req1_a(r1a[g]), .req1_b(r1b[g]), .req1_c(r1c[g]),
      .alu_op(aop[g]), .alu_a(aa[g]), .alu_b(ab[g]), .alu_c(ac[g]),
      .alu_result(ares[g]),
      .rsp_valid(rv[g]), .rsp_ready(rrdy[g]), .rsp_id(rid[g]), .rsp_result(rres[g])
    );
    assign ares[g] = alu_model(aop[g], aa[g], ab[g], ac[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int g, input logic id, input logic val, input vec_t v);
    if (id) begin
      r1v[g] = val; r1op[g] = v.op; r1a[g] = v.a; r1b[g] = v.b; r1c[g] = v.c;
    end else begin
      r0v[g] = val; r0op[g] = v.op; r0a[g] = v.a; r0b[g] = v.b; r0c[g] = v.c;
    end
  endtask

  task automatic reset_dut(input int g);
    @(posedge clk); #1;
    rstn[g] = 1'b0;
    @(posedge clk); #1;
    rstn[g] = 1'b1;
  endtask

  // Returns the number of clock edges after the current one until rsp_valid is seen.
  task automatic wait_rsp(input int g, output int lat);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (rv[g]) lat = i;
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic rsp_handshake(input int g);
    rrdy[g] = 1'b1;
    @(posedge clk); #1;
    rrdy[g] = 1'b0;
    chk("rsp_valid_drop", 32'(rv[g]), 32'd0);
  endtask

  task automatic do_op(input int g, input vec_t v, input int lat_exp);
    int lat;
    @(posedge clk); #1;
    drive(g, v.id, 1'b1, v);
    @(negedge clk);
    chk("ready_granted", 32'(v.id ? r1rdy[g] : r0rdy[g]), 32'd1);
    chk("ready_other",   32'(v.id ? r0rdy[g] : r1rdy[g]), 32'd0);
    @(posedge clk); #1;
    drive(g, v.id, 1'b0, v);
    chk("alu_op", 32'(aop[g]), 32'(v.op));
    chk("alu_a", aa[g], v.a);
    chk("alu_b", ab[g], v.b);
    chk("alu_c", 32'(ac[g]), 32'(v.c));
    wait_rsp(g, lat);
    chk("latency", 32'(lat), 32'(lat_exp));
    chk("rsp_id", 32'(rid[g]), 32'(v.id));
    chk("rsp_result", rres[g], v.exp);
    rsp_handshake(g);
  endtask

  initial begin
    int lat;
    int n;
    int cyc;
    int prev;
    int seen;
    vec_t v0;
    vec_t v1;

    for (int g = 0; g < 2; g++) begin
      rstn[g] = 1'b0; rrdy[g] = 1'b0;
      r0v[g] = 1'b0; r0op[g] = 4'd0; r0a[g] = 32'd0; r0b[g] = 32'd0; r0c[g] = 5'd0;
      r1v[g] = 1'b0; r1op[g] = 4'd0; r1a[g] = 32'd0; r1b[g] = 32'd0; r1c[g] = 5'd0;
    end

    vecs[0] = '{4'd0, 32'd5,          32'd7,          5'd0,  1'b0, 32'd12};
    vecs[1] = '{4'd1, 32'd9,          32'd4,          5'd0,  1'b1, 32'd5};
    vecs[2] = '{4'd3, 32'h0000_DEAD,  32'h0000_DEAD,  5'd0,  1'b0, 32'd1};
    vecs[3] = '{4'd4, 32'd0,          32'h0000_1234,  5'd0,  1'b0, 32'h1234_0000};
    vecs[4] = '{4'd6, 32'd0,          32'd1,          5'd31, 1'b1, 32'h8000_0000};
    vecs[5] = '{4'd5, 32'hCAFE_BABE,  32'd3,          5'd2,  1'b1, 32'hCAFE_BABE};
    vecs[6] = '{4'd9, 32'd1,          32'd2,          5'd3,  1'b0, 32'd0};
    vecs[7] = '{4'd3, 32'd1,          32'd2,          5'd0,  1'b1, 32'd0};

    #12;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rv[0]), 32'd0);
    chk("reset_rsp_id", 32'(rid[0]), 32'd0);
    chk("reset_rsp_result", rres[0], 32'd0);
    chk("reset_alu_b", ab[0], 32'd0);
    chk("reset_ready0", 32'(r0rdy[0]), 32'd0);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    for (int i = 0; i < 8; i++) do_op(0, vecs[i], 1);

    // Tie straight after reset: req0 first, then req1 once the response is taken.
    reset_dut(0);
    v0 = '{4'd1, 32'd9, 32'd4, 5'd0, 1'b0, 32'd5};
    v1 = '{4'd2, 32'h0000_00F0, 32'h0000_000F, 5'd0, 1'b1, 32'h0000_00FF};
    drive(0, 1'b0, 1'b1, v0);
    drive(0, 1'b1, 1'b1, v1);
    @(negedge clk);
    chk("tie_ready0", 32'(r0rdy[0]), 32'd1);
    chk("tie_ready1", 32'(r1rdy[0]), 32'd0);
    @(posedge clk); #1;
    r0v[0] = 1'b0;
    wait_rsp(0, lat);
    chk("tie_first_id", 32'(rid[0]), 32'd0);
    chk("tie_first_result", rres[0], 32'd5);
    chk("tie_hold_ready1", 32'(r1rdy[0]), 32'd0);
    rsp_handshake(0);
    @(negedge clk);
    chk("tie_second_ready1", 32'(r1rdy[0]), 32'd1);
    @(posedge clk); #1;
    r1v[0] = 1'b0;
    wait_rsp(0, lat);
    chk("tie_second_id", 32'(rid[0]), 32'd1);
    chk("tie_second_result", rres[0], 32'h0000_00FF);
    rsp_handshake(0);

    // Stalled response with both requesters pending: everything must stay frozen.
    v0 = '{4'd0, 32'd100, 32'd23, 5'd0, 1'b0, 32'd123};
    v1 = '{4'd2, 32'd1, 32'd2, 5'd0, 1'b1, 32'd3};
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, v0);
    drive(0, 1'b1, 1'b1, v1);
    wait_rsp(0, lat);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", 32'(rv[0]), 32'd1);
      chk("stall_rsp_id", 32'(rid[0]), 32'd0);
      chk("stall_rsp_result", rres[0], 32'd123);
      chk("stall_readys", 32'({r0rdy[0], r1rdy[0]}), 32'd0);
      chk("stall_alu_a", aa[0], 32'd100);
      chk("stall_alu_b", ab[0], 32'd23);
      @(negedge clk);
    end
    rrdy[0] = 1'b1;
    @(posedge clk); #1;
    rrdy[0] = 1'b0;
    r0v[0] = 1'b0;
    r1v[0] = 1'b0;

    // Both held valid: strict alternation, one op every EXEC_CYCLES+2 cycles.
    reset_dut(0);
    v0 = '{4'd0, 32'd1, 32'd2, 5'd0, 1'b0, 32'd3};
    v1 = '{4'd1, 32'd10, 32'd3, 5'd0, 1'b1, 32'd7};
    drive(0, 1'b0, 1'b1, v0);
    drive(0, 1'b1, 1'b1, v1);
    rrdy[0] = 1'b1;
    n = 0; prev = 0;
    for (cyc = 0; cyc < 60 && n < 6; cyc++) begin
      @(negedge clk);
      if (rv[0]) begin
        chk("rr_id", 32'(rid[0]), 32'(n % 2));
        chk("rr_result", rres[0], (n % 2 == 1) ? 32'd7 : 32'd3);
        if (n > 0) chk("rr_spacing", 32'(cyc - prev), 32'd3);
        prev = cyc;
        n++;
      end
    end
    r0v[0] = 1'b0;
    r1v[0] = 1'b0;
    chk("rr_count", 32'(n), 32'd6);
    @(posedge clk); #1;
    rrdy[0] = 1'b0;

    // EXEC_CYCLES=3 instance: normal shift, then aborts in EXEC and in HOLD.
    v1 = '{4'd6, 32'd0, 32'd1, 5'd31, 1'b1, 32'h8000_0000};
    do_op(1, v1, 3);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, v1);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, v1);
    @(negedge clk);
    rstn[1] = 1'b0;
    #1;
    chk("abort_exec_alu_op", 32'(aop[1]), 32'd0);
    chk("abort_exec_alu_b", ab[1], 32'd0);
    chk("abort_exec_alu_c", 32'(ac[1]), 32'd0);
    chk("abort_exec_rsp_id", 32'(rid[1]), 32'd0);
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv[1]) seen++;
    end
    chk("abort_exec_no_rsp", 32'(seen), 32'd0);

    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, v1);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, v1);
    wait_rsp(1, lat);
    chk("abort_hold_pre_valid", 32'(rv[1]), 32'd1);
    rstn[1] = 1'b0;
    #1;
    chk("abort_hold_rsp_valid", 32'(rv[1]), 32'd0);
    chk("abort_hold_rsp_result", rres[1], 32'd0);
    @(posedge clk); #1;
    rstn[1] = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
